// File: rtl/isqrt_dispatch_ctrl.sv
// In-order dispatch controller for a pool of external isqrt workers.
// Arguments go to workers round-robin; results are returned in acceptance order.
module isqrt_dispatch_ctrl #(
   parameter int unsigned N_WORKERS = 4,
   parameter int unsigned WIDTH     = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             arg_vld,
   output logic                             arg_rdy,
   input  logic [WIDTH-1:0]                 arg,
   output logic [N_WORKERS-1:0]             w_start,
   output logic [WIDTH-1:0]                 w_x,
   input  logic [N_WORKERS-1:0]             w_done,
   input  logic [N_WORKERS*(WIDTH/2)-1:0]   w_y,
   output logic                             res_vld,
   input  logic                             res_rdy,
   output logic [WIDTH/2-1:0]               res,
   output logic                             busy,
   output logic                             err
);

   localparam int unsigned RW    = WIDTH / 2;
   localparam int unsigned PTR_W = $clog2(N_WORKERS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } slot_state_e;

   slot_state_e          slot_q  [N_WORKERS];
   slot_state_e          slot_d  [N_WORKERS];
   logic [RW-1:0]        res_q   [N_WORKERS];
   logic [RW-1:0]        res_d   [N_WORKERS];
   logic [PTR_W-1:0]     in_ptr_q,  in_ptr_d;
   logic [PTR_W-1:0]     out_ptr_q, out_ptr_d;
   logic                 err_q,     err_d;

   // State register: slot states, result registers, ring pointers, sticky error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(N_WORKERS); i++) begin
            slot_q[i] <= S_IDLE;
            res_q[i]  <= '0;
         end
         in_ptr_q  <= '0;
         out_ptr_q <= '0;
         err_q     <= 1'b0;
      end else begin
         for (int i = 0; i < int'(N_WORKERS); i++) begin
            slot_q[i] <= slot_d[i];
            res_q[i]  <= res_d[i];
         end
         in_ptr_q  <= in_ptr_d;
         out_ptr_q <= out_ptr_d;
         err_q     <= err_d;
      end
   end

   // Next-state and output decode; outputs depend only on registered state
   // except w_start, which is the dispatch handshake itself.
   always_comb begin
      for (int i = 0; i < int'(N_WORKERS); i++) begin
         slot_d[i] = slot_q[i];
         res_d[i]  = res_q[i];
      end
      in_ptr_d  = in_ptr_q;
      out_ptr_d = out_ptr_q;
      err_d     = err_q;
      w_start   = '0;
      busy      = 1'b0;

      arg_rdy = (slot_q[in_ptr_q] == S_IDLE);
      res_vld = (slot_q[out_ptr_q] == S_DONE);
      res     = res_q[out_ptr_q];
      err     = err_q;

      // A done pulse on a slot that is not waiting for one is a protocol error.
      for (int i = 0; i < int'(N_WORKERS); i++) begin
         if (w_done[i]) begin
            if (slot_q[i] == S_BUSY) begin
               slot_d[i] = S_DONE;
               res_d[i]  = w_y[i*RW +: RW];
            end else begin
               err_d = 1'b1;
            end
         end
      end

      if (arg_vld && arg_rdy) begin
         w_start[in_ptr_q] = 1'b1;
         slot_d[in_ptr_q]  = S_BUSY;
         in_ptr_d          = in_ptr_q + PTR_W'(1);
      end

      // A freed slot only becomes visible to arg_rdy after the clock edge.
      if (res_vld && res_rdy) begin
         slot_d[out_ptr_q] = S_IDLE;
         out_ptr_d         = out_ptr_q + PTR_W'(1);
      end

      for (int i = 0; i < int'(N_WORKERS); i++) begin
         if (slot_q[i] != S_IDLE) busy = 1'b1;
      end
   end

   assign w_x = arg;

endmodule

// File: tb/tb_isqrt_dispatch_ctrl.sv
// Directed bench for isqrt_dispatch_ctrl with a result-order scoreboard.
module tb_isqrt_dispatch_ctrl;

   localparam int unsigned NW = 4;
   localparam int unsigned W  = 32;
   localparam int unsigned RW = W / 2;

   logic              clk;
   logic              rst;
   logic              arg_vld;
   logic              arg_rdy;
   logic [W-1:0]      arg;
   logic [NW-1:0]     w_start;
   logic [W-1:0]      w_x;
   logic [NW-1:0]     w_done;
   logic [NW*RW-1:0]  w_y;
   logic              res_vld;
   logic              res_rdy;
   logic [RW-1:0]     res;
   logic              busy;
   logic              err;

   int                errors;
   int                checks;
   logic [RW-1:0]     exp_q [$];
   logic [W-1:0]      wk_arg [NW];
   logic [1:0]        m_in;

   isqrt_dispatch_ctrl #(.N_WORKERS(NW), .WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .arg_vld (arg_vld),
      .arg_rdy (arg_rdy),
      .arg     (arg),
      .w_start (w_start),
      .w_x     (w_x),
      .w_done  (w_done),
      .w_y     (w_y),
      .res_vld (res_vld),
      .res_rdy (res_rdy),
      .res     (res),
      .busy    (busy),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [RW-1:0] isqrt(input logic [W-1:0] x);
      longint unsigned r;
      longint unsigned t;
      r = 0;
      for (int b = int'(RW) - 1; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= longint'(x)) r = t;
      end
      return RW'(r);
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes at the falling edge, then return just after the rising edge.
   task automatic tick();
      logic [RW-1:0] e;
      @(negedge clk);
      if (!rst) begin
         m_in = '0;
         exp_q.delete();
      end else begin
         chk("w_x", w_x, arg);
         if (arg_vld && arg_rdy) begin
            chk("w_start", W'(w_start), W'(4'(4'b0001 << m_in)));
            wk_arg[m_in] = arg;
            exp_q.push_back(isqrt(arg));
            m_in = m_in + 2'd1;
         end else begin
            chk("w_start_idle", W'(w_start), '0);
         end
         if (res_vld && res_rdy) begin
            if (exp_q.size() == 0) begin
               chk("res_unexpected", W'(res_vld), '0);
            end else begin
               e = exp_q.pop_front();
               chk("res_order", W'(res), W'(e));
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic send(input logic [W-1:0] a);
      arg     = a;
      arg_vld = 1'b1;
      for (int k = 0; k < 20 && !arg_rdy; k++) tick();
      chk("send_rdy", W'(arg_rdy), W'(1));
      tick();
      arg_vld = 1'b0;
   endtask

   task automatic done_mask(input logic [NW-1:0] m);
      w_done = m;
      for (int i = 0; i < int'(NW); i++) begin
         if (m[i]) w_y[i*RW +: RW] = isqrt(wk_arg[i]);
      end
      tick();
      w_done = '0;
      w_y    = '0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick();
      chk("drain_empty", W'(exp_q.size()), '0);
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      m_in    = '0;
      rst     = 1'b0;
      arg_vld = 1'b0;
      arg     = '0;
      res_rdy = 1'b0;
      w_done  = '0;
      w_y     = '0;
      for (int i = 0; i < int'(NW); i++) wk_arg[i] = '0;

      #1;
      chk("rst_arg_rdy", W'(arg_rdy), W'(1));
      chk("rst_w_start", W'(w_start), '0);
      chk("rst_res_vld", W'(res_vld), '0);
      chk("rst_res",     W'(res), '0);
      chk("rst_busy",    W'(busy), '0);
      chk("rst_err",     W'(err), '0);
      tick();
      tick();
      rst = 1'b1;

      // Single operation.
      res_rdy = 1'b1;
      send(32'd16);
      chk("t1_busy", W'(busy), W'(1));
      chk("t1_no_res", W'(res_vld), '0);
      tick();
      tick();
      done_mask(4'b0001);
      chk("t1_res_vld", W'(res_vld), W'(1));
      chk("t1_res", W'(res), W'(16'd4));
      tick();
      chk("t1_idle", W'(busy), '0);
      chk("t1_res_vld_clr", W'(res_vld), '0);

      // Out-of-order completion, in-order delivery.
      do_reset();
      res_rdy = 1'b0;
      send(32'd100);
      send(32'd49);
      send(32'd9);
      send(32'd1);
      done_mask(4'b1000);
      chk("t2_head_wait", W'(res_vld), '0);
      done_mask(4'b0100);
      done_mask(4'b0010);
      done_mask(4'b0001);
      chk("t2_res_vld", W'(res_vld), W'(1));
      chk("t2_res_head", W'(res), W'(16'd10));
      res_rdy = 1'b1;
      drain();
      chk("t2_idle", W'(busy), '0);

      // Full pool, then one-cycle bubble after a slot is freed.
      do_reset();
      res_rdy = 1'b0;
      send(32'd25);
      send(32'd36);
      send(32'd64);
      send(32'd81);
      chk("t3_full", W'(arg_rdy), '0);
      arg     = 32'd144;
      arg_vld = 1'b1;
      tick();
      chk("t3_full_hold", W'(arg_rdy), '0);
      done_mask(4'b0001);
      chk("t3_res_vld", W'(res_vld), W'(1));
      chk("t3_res", W'(res), W'(16'd5));
      res_rdy = 1'b1;
      chk("t3_bubble", W'(arg_rdy), '0);
      tick();
      res_rdy = 1'b0;
      chk("t3_rdy_after", W'(arg_rdy), W'(1));
      send(32'd144);

      // Backpressure holds the head result.
      do_reset();
      res_rdy = 1'b0;
      send(32'd144);
      send(32'd4);
      done_mask(4'b0010);
      done_mask(4'b0001);
      chk("t4_res_vld", W'(res_vld), W'(1));
      chk("t4_res", W'(res), W'(16'd12));
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t4_hold_vld", W'(res_vld), W'(1));
         chk("t4_hold_res", W'(res), W'(16'd12));
      end
      res_rdy = 1'b1;
      drain();
      chk("t4_idle", W'(busy), '0);

      // Done pulse on an idle slot.
      done_mask(4'b0100);
      chk("t5_err", W'(err), W'(1));
      chk("t5_no_res", W'(res_vld), '0);
      chk("t5_no_busy", W'(busy), '0);
      chk("t5_arg_rdy", W'(arg_rdy), W'(1));
      send(32'd9);
      done_mask(4'b0100);
      drain();
      chk("t5_err_sticky", W'(err), W'(1));
      do_reset();
      chk("t5_err_clr", W'(err), '0);

      // Asynchronous reset with work in flight.
      res_rdy = 1'b0;
      send(32'd1);
      send(32'd4);
      send(32'd9);
      chk("t6_busy", W'(busy), W'(1));
      #2;
      rst = 1'b0;
      #1;
      chk("t6_arg_rdy", W'(arg_rdy), W'(1));
      chk("t6_busy_clr", W'(busy), '0);
      chk("t6_res_vld", W'(res_vld), '0);
      tick();
      rst = 1'b1;
      done_mask(4'b0010);
      chk("t6_stale_err", W'(err), W'(1));
      chk("t6_stale_busy", W'(busy), '0);
      chk("t6_stale_res", W'(res_vld), '0);

      // Simultaneous multi-done, dispatch and result handshake.
      do_reset();
      res_rdy = 1'b0;
      send(32'd4);
      send(32'd9);
      send(32'd16);
      done_mask(4'b0001);
      chk("t7_head", W'(res_vld), W'(1));
      arg     = 32'd25;
      arg_vld = 1'b1;
      res_rdy = 1'b1;
      done_mask(4'b0110);
      arg_vld = 1'b0;
      chk("t7_no_err", W'(err), '0);
      chk("t7_next_vld", W'(res_vld), W'(1));
      chk("t7_next_res", W'(res), W'(16'd3));
      done_mask(4'b1000);
      drain();
      chk("t7_idle", W'(busy), '0);
      chk("t7_err", W'(err), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
